// File: rtl/alu_result_buf.sv
// Two-entry result buffer behind the 12:1 ALU result selector.
// Stores status flags, replaces the result of an illegal select with zero, and counts illegal selects.
module alu_result_buf #(
  parameter int WIDTH   = 16,
  parameter int SEL_W   = 4,
  parameter int NUM_OPS = 12,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             ovf;
    logic             ill;
  } entry_t;

  // One extra bit lets NUM_OPS equal 2**SEL_W without overflowing the comparison.
  localparam logic [SEL_W:0]   NUM_OPS_L = NUM_OPS[SEL_W:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_done_q, rst_done_d;

  entry_t new_entry;
  logic   push;
  logic   pop;

  // in_ready stays low until one clock edge has passed with reset released.
  assign in_ready  = rst_done_q && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry      = '0;
    new_entry.sel  = in_sel;
    new_entry.ill  = ({1'b0, in_sel} >= NUM_OPS_L);
    new_entry.data = new_entry.ill ? '0 : in_data;
    new_entry.ovf  = new_entry.ill ? 1'b0 : in_ovf;
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    rst_done_d = 1'b1;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = TWO;
        end else if (pop) begin
          head_d  = '0;
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        head_d  = '0;
        tail_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (push && new_entry.ill && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      rst_done_q <= rst_done_d;
    end
  end

  // head_q is cleared whenever the buffer empties, so gating is only needed for the zero flag.
  assign out_data    = head_q.data;
  assign out_sel     = head_q.sel;
  assign out_ovf     = head_q.ovf;
  assign out_illegal = head_q.ill;
  assign out_neg     = head_q.data[WIDTH-1];
  assign out_zero    = out_valid && (head_q.data == '0);
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_buf.sv
// Testbench for alu_result_buf: directed scenarios and random traffic, checked against a queue-based model.
module tb_alu_result_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_sel;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;
  logic        cnt_clr;

  alu_result_buf #(.WIDTH(16), .SEL_W(4), .NUM_OPS(12), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_zero(out_zero), .out_neg(out_neg),
    .out_ovf(out_ovf), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned data;
    int unsigned sel;
    int unsigned ovf;
    int unsigned ill;
  } ref_entry_t;

  ref_entry_t  mq[$];
  int unsigned m_cnt;
  bit          m_rst_done;
  int unsigned n_vec;
  int unsigned n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one clock of stimulus (called just after a negedge), advance the model, compare at the next negedge.
  task automatic cycle(input bit v, input logic [15:0] d, input logic [3:0] s,
                       input bit o, input bit ordy, input bit clr);
    bit         m_ready;
    bit         do_push;
    bit         do_pop;
    ref_entry_t e;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_ovf    = o;
    out_ready = ordy;
    cnt_clr   = clr;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_cnt      = 0;
      m_rst_done = 1'b0;
    end else begin
      m_ready = m_rst_done && (mq.size() < 2);
      do_push = v && m_ready;
      do_pop  = ordy && (mq.size() > 0);
      e.ill   = (int'(s) >= 12) ? 1 : 0;
      e.sel   = s;
      e.data  = (e.ill != 0) ? 0 : int'(d);
      e.ovf   = (e.ill != 0) ? 0 : int'(o);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
      if (clr) m_cnt = 0;
      else if (do_push && e.ill != 0 && m_cnt < 255) m_cnt++;
      m_rst_done = 1'b1;
    end
    @(negedge clk);
    chk("in_ready", in_ready, (m_rst_done && mq.size() < 2) ? 1 : 0);
    chk("out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0].data);
      chk("out_sel", out_sel, mq[0].sel);
      chk("out_ovf", out_ovf, mq[0].ovf);
      chk("out_illegal", out_illegal, mq[0].ill);
      chk("out_zero", out_zero, (mq[0].data == 0) ? 1 : 0);
      chk("out_neg", out_neg, (mq[0].data >= 32'h8000) ? 1 : 0);
    end else begin
      chk("out_empty", {out_data, out_sel, out_zero, out_neg, out_ovf, out_illegal}, 0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    m_cnt = 0;
    m_rst_done = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);

    // Reset held for two clocks, then released
    cycle(0, 16'h0, 4'h0, 0, 0, 0);
    cycle(0, 16'h0, 4'h0, 0, 0, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt", illegal_cnt, 0);
    rst_n = 1'b1;
    cycle(0, 16'h0, 4'h0, 0, 0, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Single pass with negative, overflowing result
    cycle(1, 16'h8000, 4'd3, 1, 0, 0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'h8000);
    chk("single_neg", out_neg, 1);
    chk("single_zero", out_zero, 0);
    chk("single_ovf", out_ovf, 1);
    cycle(0, 16'h0, 4'h0, 0, 1, 0);

    // Backpressure: fill both entries, then drain in order
    cycle(1, 16'h0001, 4'd1, 0, 0, 0);
    cycle(1, 16'h0002, 4'd2, 0, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head1", out_data, 32'h0001);
    cycle(1, 16'h0003, 4'd2, 0, 0, 0);
    chk("bp_hold", out_data, 32'h0001);
    cycle(0, 16'h0, 4'h0, 0, 1, 0);
    chk("bp_head2", out_data, 32'h0002);
    cycle(0, 16'h0, 4'h0, 0, 1, 0);
    chk("bp_drained", out_valid, 0);

    // Illegal select
    cycle(1, 16'hFFFF, 4'd13, 1, 0, 0);
    chk("ill_data", out_data, 0);
    chk("ill_zero", out_zero, 1);
    chk("ill_ovf", out_ovf, 0);
    chk("ill_flag", out_illegal, 1);
    chk("ill_cnt", illegal_cnt, 1);
    cycle(0, 16'h0, 4'h0, 0, 1, 0);

    // Push and pop on the same edge while holding one entry
    cycle(1, 16'h0005, 4'd0, 0, 0, 0);
    cycle(1, 16'h0006, 4'd0, 0, 1, 0);
    chk("simul_valid", out_valid, 1);
    chk("simul_ready", in_ready, 1);
    chk("simul_data", out_data, 32'h0006);
    cycle(0, 16'h0, 4'h0, 0, 1, 0);

    // Saturation, clear priority, reset while full
    cycle(0, 16'h0, 4'h0, 0, 0, 1);
    for (int i = 0; i < 300; i++) cycle(1, 16'($urandom), 4'd12 + 4'($urandom_range(0, 3)), 1, 1, 0);
    chk("sat_cnt", illegal_cnt, 255);
    cycle(1, 16'h1234, 4'd15, 0, 1, 1);
    chk("clr_prio", illegal_cnt, 0);
    cycle(0, 16'h0, 4'h0, 0, 1, 0);
    cycle(1, 16'h00AA, 4'd4, 0, 0, 0);
    cycle(1, 16'h00BB, 4'd5, 0, 0, 0);
    chk("full_before_rst", in_ready, 0);
    rst_n = 1'b0;
    cycle(0, 16'h0, 4'h0, 0, 0, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    rst_n = 1'b1;
    cycle(0, 16'h0, 4'h0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
